// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - tone period measurement, note classification, debounce and PASS/FAIL melody detection (optional TONE_DEBUG_EN adds meas_period)

module tone_decoder #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int STABLE_CNT   = 4,
    parameter int SILENCE_CLKS = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [2:0]  note_code,
    output logic        note_valid,
    output logic        tone_present,
    output logic        detect_pass,
    output logic        detect_fail
`ifdef TONE_DEBUG_EN
    ,
    output logic [19:0] meas_period
`endif
);

    // Nominal periods in clocks, indexed by note code minus one.
    localparam int NOM [7] = '{CLK_HZ / 440, CLK_HZ / 523, CLK_HZ / 554, CLK_HZ / 587,
                               CLK_HZ / 659, CLK_HZ / 784, CLK_HZ / 1047};
    localparam logic [19:0] SIL_MAX  = 20'(SILENCE_CLKS);
    localparam logic [19:0] SIL_LAST = 20'(SILENCE_CLKS - 1);
    localparam logic [3:0]  STABLE   = 4'(STABLE_CNT);

    // Overlapping tolerance windows resolve to the lowest note code.
    function automatic logic [2:0] classify(input logic [19:0] p);
        int pv;
        int lo;
        int hi;
        classify = 3'd0;
        pv = int'({12'd0, p});
        for (int i = 6; i >= 0; i--) begin
            lo = NOM[i] - (NOM[i] >>> 5);
            hi = NOM[i] + (NOM[i] >>> 5);
            if (pv >= lo && pv <= hi) classify = 3'(i + 1);
        end
    endfunction

    function automatic logic [2:0] pass_at(input logic [2:0] i);
        case (i)
            3'd0:    pass_at = 3'd2;
            3'd1:    pass_at = 3'd5;
            3'd2:    pass_at = 3'd6;
            3'd3:    pass_at = 3'd7;
            3'd4:    pass_at = 3'd6;
            default: pass_at = 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] fail_at(input logic [1:0] i);
        case (i)
            2'd0:    fail_at = 3'd4;
            2'd1:    fail_at = 3'd3;
            2'd2:    fail_at = 3'd4;
            default: fail_at = 3'd1;
        endcase
    endfunction

    logic        sync1, sync2, sync3;
    logic [19:0] cnt;
    logic        have_edge;
    logic        note_accepted;
    logic [2:0]  cand;
    logic [3:0]  stab_cnt;
    logic [2:0]  pass_idx;
    logic [1:0]  fail_idx;

    logic        rise;
    logic        silence;
    logic [19:0] period;
    logic [2:0]  cls;
    logic [2:0]  next_cand;
    logic [3:0]  next_cnt;
    logic        accept;
    logic [2:0]  pass_nx;
    logic        pass_done;
    logic [1:0]  fail_nx;
    logic        fail_done;

    // Edge detect, period measurement, debounce candidate and melody matcher next state.
    always_comb begin
        rise    = sync2 & ~sync3;
        silence = ~rise & (cnt == SIL_LAST);
        period  = cnt + 20'd1;
        cls     = classify(period);

        if (cls == cand) begin
            next_cand = cand;
            next_cnt  = (stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1;
        end else begin
            next_cand = cls;
            next_cnt  = 4'd1;
        end

        accept = rise & have_edge & (next_cnt == STABLE) &
                 ((next_cand != note_code) | ~note_accepted);

        pass_done = 1'b0;
        if (next_cand == pass_at(pass_idx)) begin
            if (pass_idx == 3'd5) begin
                pass_nx   = 3'd0;
                pass_done = 1'b1;
            end else begin
                pass_nx = pass_idx + 3'd1;
            end
        end else begin
            pass_nx = (next_cand == pass_at(3'd0)) ? 3'd1 : 3'd0;
        end

        fail_done = 1'b0;
        if (next_cand == fail_at(fail_idx)) begin
            if (fail_idx == 2'd3) begin
                fail_nx   = 2'd0;
                fail_done = 1'b1;
            end else begin
                fail_nx = fail_idx + 2'd1;
            end
        end else begin
            fail_nx = (next_cand == fail_at(2'd0)) ? 2'd1 : 2'd0;
        end
    end

    // Synchronise tone_in and count clocks since the last rising edge, saturating at the silence limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            cnt   <= 20'd0;
        end else begin
            sync1 <= tone_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (rise)
                cnt <= 20'd0;
            else if (cnt != SIL_MAX)
                cnt <= cnt + 20'd1;
        end
    end

    // Accept debounced notes, track silence and advance both melody matchers on each accepted note.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            have_edge     <= 1'b0;
            note_accepted <= 1'b0;
            cand          <= 3'd0;
            stab_cnt      <= 4'd0;
            pass_idx      <= 3'd0;
            fail_idx      <= 2'd0;
            note_code     <= 3'd0;
            note_valid    <= 1'b0;
            tone_present  <= 1'b0;
            detect_pass   <= 1'b0;
            detect_fail   <= 1'b0;
        end else begin
            note_valid  <= 1'b0;
            detect_pass <= 1'b0;
            detect_fail <= 1'b0;
            if (silence) begin
                tone_present  <= 1'b0;
                have_edge     <= 1'b0;
                note_accepted <= 1'b0;
                cand          <= 3'd0;
                stab_cnt      <= 4'd0;
                pass_idx      <= 3'd0;
                fail_idx      <= 2'd0;
            end else if (rise) begin
                have_edge    <= 1'b1;
                tone_present <= 1'b1;
                if (have_edge) begin
                    cand     <= next_cand;
                    stab_cnt <= next_cnt;
                    if (accept) begin
                        note_code     <= next_cand;
                        note_valid    <= 1'b1;
                        note_accepted <= 1'b1;
                        pass_idx      <= pass_nx;
                        fail_idx      <= fail_nx;
                        detect_pass   <= pass_done;
                        detect_fail   <= fail_done;
                    end
                end
            end
        end
    end

`ifdef TONE_DEBUG_EN
    // Hold the most recent measured period for debug visibility.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            meas_period <= 20'd0;
        else if (rise && have_edge)
            meas_period <= period;
    end
`endif

endmodule
